// File: rtl/chacha_pkg.sv
// Shared constants and types for the ChaCha byte-serial front end.
package chacha_pkg;

    localparam int WORDS  = 16;               // state words per block, power of two
    localparam int ADDR_W = $clog2(WORDS);    // word address width

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_REQ   = 2'd1,
        RD_WAIT  = 2'd2,
        RD_SHIFT = 2'd3
    } rd_state_t;

endpackage

// File: rtl/chacha_word_packer.sv
// Load path: packs input bytes little-endian into 32-bit words and hands
// each finished word to the core over a valid/ready write port.
module chacha_word_packer
    import chacha_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_restart,
    input  logic [7:0]        i_in_byte,
    input  logic              i_in_strobe,
    output logic              o_in_busy,
    output logic              o_overflow,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_load_done
);

    logic [1:0]        r_bcnt;
    word_t             r_data;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_overflow;
    logic              r_load_done;

    logic w_hs;
    logic w_busy;
    logic w_accept;
    logic w_last;

    // The shift register can take byte0 of the next word in the handshake
    // cycle because the current word leaves on that same edge.
    assign w_hs     = r_wr_valid & i_wr_ready;
    assign w_busy   = r_wr_valid & ~i_wr_ready;
    assign w_accept = i_in_strobe & ~w_busy;
    assign w_last   = w_accept & (r_bcnt == 2'd3);

    // Byte packing, write handshake, address and sticky overflow state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bcnt      <= '0;
            r_data      <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_overflow  <= 1'b0;
            r_load_done <= 1'b0;
        end else if (i_restart) begin
            // Pending word is dropped; stale data bytes are overwritten later.
            r_bcnt      <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_addr   <= '0;
            r_overflow  <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data[{r_bcnt, 3'b000} +: 8] <= i_in_byte;
                r_bcnt                        <= r_bcnt + 2'd1;
            end
            if (w_last)
                r_wr_valid <= 1'b1;
            else if (w_hs)
                r_wr_valid <= 1'b0;
            if (w_hs)
                r_wr_addr <= r_wr_addr + 1'b1;   // wraps naturally at WORDS
            r_load_done <= w_hs & (r_wr_addr == ADDR_W'(WORDS - 1));
            if (i_in_strobe & w_busy)
                r_overflow <= 1'b1;
        end
    end

    assign o_in_busy   = w_busy;
    assign o_overflow  = r_overflow;
    assign o_wr_valid  = r_wr_valid;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_data;
    assign o_load_done = r_load_done;

endmodule

// File: rtl/chacha_byte_serdes.sv
// Byte-serial front end for the ChaCha block core: byte packer on the load
// side, read FSM plus byte unpacker on the result side. Paths are independent.
module chacha_byte_serdes
    import chacha_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_restart,
    input  logic [7:0]        i_in_byte,
    input  logic              i_in_strobe,
    output logic              o_in_busy,
    output logic              o_overflow,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_load_done,
    input  logic              i_rd_start,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_valid,
    input  logic [31:0]       i_rd_data,
    output logic [7:0]        o_out_byte,
    output logic              o_out_valid,
    input  logic              i_out_advance,
    output logic              o_read_done
);

    chacha_word_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_restart   (i_restart),
        .i_in_byte   (i_in_byte),
        .i_in_strobe (i_in_strobe),
        .o_in_busy   (o_in_busy),
        .o_overflow  (o_overflow),
        .o_wr_valid  (o_wr_valid),
        .i_wr_ready  (i_wr_ready),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_load_done (o_load_done)
    );

    rd_state_t         r_state, w_state_nx;
    logic [ADDR_W-1:0] r_widx,  w_widx_nx;
    logic [1:0]        r_bidx,  w_bidx_nx;
    word_t             r_word;
    logic              r_read_done, w_done_nx;
    logic              w_latch;

    // Read FSM state, word/byte indices, latched word and done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= RD_IDLE;
            r_widx      <= '0;
            r_bidx      <= '0;
            r_word      <= '0;
            r_read_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_widx      <= w_widx_nx;
            r_bidx      <= w_bidx_nx;
            r_read_done <= w_done_nx;
            if (w_latch)
                r_word <= i_rd_data;
        end
    end

    // Next-state logic; restart wins over every other input.
    always_comb begin
        w_state_nx = r_state;
        w_widx_nx  = r_widx;
        w_bidx_nx  = r_bidx;
        w_done_nx  = 1'b0;
        w_latch    = 1'b0;
        if (i_restart) begin
            w_state_nx = RD_IDLE;
            w_widx_nx  = '0;
            w_bidx_nx  = '0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    if (i_rd_start) begin
                        w_state_nx = RD_REQ;
                        w_widx_nx  = '0;
                        w_bidx_nx  = '0;
                    end
                end
                // The core may answer in the request cycle itself.
                RD_REQ, RD_WAIT: begin
                    if (i_rd_valid) begin
                        w_latch    = 1'b1;
                        w_state_nx = RD_SHIFT;
                        w_bidx_nx  = '0;
                    end else begin
                        w_state_nx = RD_WAIT;
                    end
                end
                RD_SHIFT: begin
                    if (i_out_advance) begin
                        if (r_bidx == 2'd3) begin
                            w_bidx_nx = '0;
                            if (r_widx == ADDR_W'(WORDS - 1)) begin
                                w_state_nx = RD_IDLE;
                                w_done_nx  = 1'b1;
                            end else begin
                                w_state_nx = RD_REQ;
                                w_widx_nx  = r_widx + 1'b1;
                            end
                        end else begin
                            w_bidx_nx = r_bidx + 2'd1;
                        end
                    end
                end
                default: w_state_nx = RD_IDLE;
            endcase
        end
    end

    assign o_rd_req    = (r_state == RD_REQ);
    assign o_rd_addr   = r_widx;
    assign o_out_valid = (r_state == RD_SHIFT);
    assign o_out_byte  = o_out_valid ? r_word[{r_bidx, 3'b000} +: 8] : 8'h00;
    assign o_read_done = r_read_done;

endmodule

// File: tb/tb_chacha_byte_serdes.sv
// Scoreboard bench: stimulus pushes expected writes/bytes into queues,
// negedge monitors pop and compare whenever the DUT presents data.
module tb_chacha_byte_serdes;

    localparam int NW = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic [7:0]  in_byte;
    logic        in_strobe;
    logic        in_busy, overflow, wr_valid, load_done;
    logic        wr_ready;
    logic [3:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic        rd_start, rd_req, rd_valid;
    logic [7:0]  out_byte;
    logic        out_valid, out_advance, read_done;

    chacha_byte_serdes dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart),
        .i_in_byte(in_byte), .i_in_strobe(in_strobe),
        .o_in_busy(in_busy), .o_overflow(overflow),
        .o_wr_valid(wr_valid), .i_wr_ready(wr_ready),
        .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_load_done(load_done),
        .i_rd_start(rd_start), .o_rd_req(rd_req), .o_rd_addr(rd_addr),
        .i_rd_valid(rd_valid), .i_rd_data(rd_data),
        .o_out_byte(out_byte), .o_out_valid(out_valid),
        .i_out_advance(out_advance), .o_read_done(read_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_load_done = 0;
    int n_read_done = 0;
    int n_consumed  = 0;
    bit adv_en = 1'b0;

    logic [35:0] exp_wr[$];    // {addr, word}
    logic [7:0]  exp_out[$];
    logic [7:0]  m_buf[$];     // bytes of the word being assembled
    int          m_addr = 0;
    logic [31:0] mem[NW];      // core-side state words

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every four accepted bytes form one little-endian word.
    task automatic model_byte(input logic [7:0] b);
        m_buf.push_back(b);
        if (m_buf.size() == 4) begin
            exp_wr.push_back({4'(m_addr), m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
            m_addr = (m_addr + 1) % NW;
            m_buf.delete();
        end
    endtask

    task automatic model_clear();
        m_buf.delete();
        m_addr = 0;
        exp_wr.delete();
        exp_out.delete();
    endtask

    task automatic load(input int n, input logic [7:0] base, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            in_byte = b;
            in_strobe = 1'b1;
            model_byte(b);
            tick();
            in_strobe = 1'b0;
            if (rnd) repeat ($urandom % 3) tick();
        end
    endtask

    task automatic drain();
        int t = 0;
        while (exp_wr.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        chk("wr_drain", exp_wr.size(), 0);
    endtask

    task automatic push_read();
        for (int k = 0; k < NW; k++)
            for (int j = 0; j < 4; j++)
                exp_out.push_back(mem[k][8*j +: 8]);
    endtask

    task automatic read_all();
        int t = 0;
        int nd0 = n_read_done;
        adv_en = 1'b1;
        push_read();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        while (n_read_done == nd0 && t < 3000) begin
            tick();
            t++;
        end
        tick();
        chk("read_done_count", n_read_done - nd0, 1);
        chk("read_queue_empty", exp_out.size(), 0);
        chk("read_idle_out_valid", out_valid, 0);
        chk("read_idle_rd_req", rd_req, 0);
        adv_en = 1'b0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        model_clear();
        tick();
        restart = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {in_busy, overflow, wr_valid, wr_addr, wr_data, load_done,
                 rd_req, rd_addr, out_byte, out_valid, read_done}, 64'd0);
    endtask

    // Write-port monitor.
    always @(negedge clk) begin
        logic [35:0] e;
        if (rst_n && !restart && wr_valid && wr_ready) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", {wr_addr, wr_data}, 36'd0);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", wr_addr, e[35:32]);
                chk("wr_data", wr_data, e[31:0]);
            end
        end
        if (rst_n && load_done) n_load_done++;
        if (rst_n && read_done) n_read_done++;
    end

    // Output-byte monitor.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst_n && !restart && out_valid && out_advance) begin
            n_consumed++;
            if (exp_out.size() == 0) begin
                chk("out_unexpected", out_byte, 8'd0);
            end else begin
                e = exp_out.pop_front();
                chk("out_byte", out_byte, e);
            end
        end
    end

    // Core model: answers each read request two cycles later.
    initial begin
        logic       p0 = 1'b0, p1 = 1'b0;
        logic [3:0] a0 = '0, a1 = '0;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            tick();
            rd_valid = p1;
            rd_data  = p1 ? mem[a1] : 32'h0;
            p1 = p0; a1 = a0;
            p0 = rd_req; a0 = rd_addr;
        end
    end

    // Random consumer on the byte output.
    initial begin
        out_advance = 1'b0;
        forever begin
            tick();
            out_advance = adv_en && ($urandom % 4 != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n0, t;
        rst_n = 1'b0; restart = 1'b0; in_byte = '0; in_strobe = 1'b0;
        wr_ready = 1'b0; rd_start = 1'b0;
        for (int k = 0; k < NW; k++) mem[k] = 32'h11111111 * k;
        repeat (3) tick();
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        tick();
        chk_zero("post_reset_outputs");

        // Sequential load 0x00..0x3F, back-to-back with ready high.
        wr_ready = 1'b1;
        n0 = n_load_done;
        load(64, 8'h00, 1'b0);
        drain();
        tick();
        chk("load_done_count", n_load_done - n0, 1);
        chk("load_overflow", overflow, 0);
        chk("load_addr_wrap", wr_addr, 0);

        // Stall: word pending with ready low, extra strobe is dropped.
        wr_ready = 1'b0;
        load(4, 8'hC0, 1'b0);
        chk("stall_busy", in_busy, 1);
        in_byte = 8'hAA;
        in_strobe = 1'b1;
        tick();
        in_strobe = 1'b0;
        chk("stall_overflow", overflow, 1);
        chk("stall_data", wr_data, 32'hC3C2C1C0);
        repeat (3) tick();
        chk("stall_data_held", wr_data, 32'hC3C2C1C0);
        chk("stall_valid_held", wr_valid, 1);
        wr_ready = 1'b1;
        load(4, 8'hD0, 1'b0);
        drain();
        chk("stall_overflow_sticky", overflow, 1);
        do_restart();
        chk("restart_clears_overflow", overflow, 0);

        // Read with the k*0x11111111 pattern.
        read_all();

        // Random read concurrently with a random, gappy load.
        for (int k = 0; k < NW; k++) mem[k] = $urandom;
        n0 = n_load_done;
        fork
            load(64, 8'h00, 1'b1);
            read_all();
        join
        drain();
        tick();
        chk("concurrent_load_done", n_load_done - n0, 1);

        // Restart mid-read at about byte 10.
        for (int k = 0; k < NW; k++) mem[k] = $urandom;
        n0 = n_consumed;
        adv_en = 1'b1;
        push_read();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        t = 0;
        while (n_consumed - n0 < 10 && t < 500) begin
            tick();
            t++;
        end
        chk("midread_reached", (n_consumed - n0 >= 10), 1);
        do_restart();
        adv_en = 1'b0;
        chk("midread_out_valid", out_valid, 0);
        repeat (4) tick();

        // Restart mid-load: two words plus two bytes, then restart.
        load(10, 8'h40, 1'b0);
        drain();
        do_restart();
        chk("midload_wr_addr", wr_addr, 0);
        chk("midload_wr_valid", wr_valid, 0);
        n0 = n_load_done;
        load(64, 8'h00, 1'b1);
        drain();
        tick();
        chk("after_restart_load_done", n_load_done - n0, 1);

        // Async reset with a word pending and the reader in SHIFT.
        wr_ready = 1'b0;
        load(4, 8'h70, 1'b0);
        for (int k = 0; k < NW; k++) mem[k] = $urandom;
        push_read();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        chk("areset_in_shift", out_valid, 1);
        chk("areset_wr_pending", wr_valid, 1);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_zero("async_reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        repeat (4) tick();
        n0 = n_load_done;
        load(64, 8'h00, 1'b0);
        drain();
        tick();
        chk("post_areset_load_done", n_load_done - n0, 1);
        chk("post_areset_overflow", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
